order_rx: RTL and testbench
===========================

Name: order_rx

Overview:
- Exchange-side receiver for the serial order link driven by the user board's transmitter: comEn (frame enable) plus data_ping_in (serial data).
- Synchronises both lines and oversamples each bit at mid-period.
- Reassembles the 32-bit order word and presents it to the matching engine with a valid/ack handshake.
- Detects framing errors, overrun and (optionally) parity errors.

Parameters:
- CLKS_PER_BIT, 6: receiver clocks per serial bit; must be ≥4 and even. Default matches the transmitter's divide-by-6 link clock.
- WORD_W, 32: order word width.

Ports:
- clock  in  1  receiver clock; all state is updated on the rising edge.
- CPU_RESETN  in  1  asynchronous, active-low reset.
- comEn  in  1  frame enable from link; asynchronous to clock.
- data_ping_in  in  1  serial data from link, MSB first; asynchronous to clock.
- order_out  out  WORD_W  last received order word.
- order_valid  out  1  order_out holds an unconsumed word.
- order_ack  in  1  consumer accepts the word; only meaningful while order_valid=1.
- frame_err  out  1  sticky framing-error flag.
- overrun  out  1  sticky overrun flag.
- busy  out  1  a frame is in progress (state ≠ IDLE).
- err_clr  in  1  synchronous clear of all sticky flags.

Behaviour:
- Reset (async, CPU_RESETN=0):
  - order_out=0, order_valid=0, frame_err=0, overrun=0, busy=0.
  - State=IDLE; all counters and synchroniser flops cleared.
- Synchronisers: comEn and data_ping_in each pass through 2 flops (comEn_s, data_s). Every latency below is counted from comEn_s.
- State machine (one-hot or binary, implementer's choice):
  - IDLE: on a comEn_s rising edge (0→1): load bit_cnt=0 and phase_cnt=1, go to SHIFT.
  - SHIFT:
    - phase_cnt counts 0..CLKS_PER_BIT-1 and wraps.
    - When phase_cnt==CLKS_PER_BIT/2, shift data_s into shift_reg LSB (MSB-first word) and increment bit_cnt.
    - After bit WORD_W-1 is sampled, go to STOP.
    - If comEn_s=0 at any sample point, set frame_err=1 and go to IDLE; the partial word is discarded.
  - STOP: wait up to CLKS_PER_BIT clocks for comEn_s=0.
    - If it drops, go to DONE.
    - On timeout with comEn_s still 1, set frame_err=1, discard the word, go to WAITLOW.
  - WAITLOW: stay until comEn_s=0, then go to IDLE. Prevents resynchronising mid-frame.
  - DONE (1 cycle):
    - If order_valid=0, or order_ack=1 this same cycle: order_out←shift_reg, order_valid=1.
    - Otherwise: overrun=1, the new word is dropped, and order_out keeps the old word.
    - Then go to IDLE.
- Handshake:
  - order_valid clears on the clock edge where order_valid=1 and order_ack=1.
  - Ack and a new load in the same cycle produce a load (order_valid stays 1, new data).
  - order_ack while order_valid=0 is ignored.
- Latency: order_valid asserts 2 clocks after comEn_s is seen low in STOP (STOP→DONE→register).
- Sticky flags:
  - Set as described above; cleared only by err_clr or reset.
  - err_clr and a set event in the same cycle: set wins.
- A comEn_s rising edge seen in any state other than IDLE is ignored; frames are never nested.

Optional Feature:
- Macro: ORDER_RX_PARITY_EN.
- When defined:
  - Frame is WORD_W+1 bits; the final bit is even parity over the word (XOR of all 33 bits ==0).
  - Adds output parity_err (1 bit, sticky, reset 0, cleared by err_clr).
  - A word with bad parity sets parity_err and is discarded in DONE; order_valid is not touched.
- When undefined:
  - Frame is exactly WORD_W bits.
  - The parity_err port does not exist.

Test Plan:
- Nominal: CLKS_PER_BIT=6. Send 0xA5C3_0F01 as 32 bits, 6 clocks per bit, comEn high for 192 clocks then low.
  - Required: order_out=0xA5C30F01 and order_valid=1 within 2+2 clocks of comEn low. With order_ack held 0, valid stays 1.
  - Pulse ack → valid=0 next edge.
- Back-to-back overrun: send 0x00000001 with no ack, then 0xFFFFFFFF.
  - Required: order_out stays 0x00000001 and overrun=1.
  - err_clr → overrun=0.
- Ack/load collision: hold order_ack=1 at the DONE cycle of a second frame 0x12345678.
  - Required: order_out=0x12345678, order_valid=1, overrun=0.
- Short frame: drop comEn after 20 bits.
  - Required: frame_err=1, order_valid unchanged, busy=0 within CLKS_PER_BIT+3 clocks.
  - A following good frame 0xDEADBEEF is received correctly.
- Long frame: hold comEn 10 bit-times past bit 31.
  - Required: frame_err=1 and no order_valid. Block ignores the line until comEn falls; the next frame 0x0000FFFF is received.
- Reset mid-frame: assert CPU_RESETN=0 at bit 15.
  - Required: all outputs 0 immediately (async). After release, a fresh frame 0x80000000 is received.
  - With ORDER_RX_PARITY_EN: 0x80000000 with parity bit 0 sets parity_err=1 and gives no valid.

Source files
------------

// File: rtl/order_rx.sv
// Serial order-link receiver: syncs comEn/data_ping_in, samples each bit at mid-period, rebuilds the word.
// Optional ORDER_RX_PARITY_EN appends an even-parity bit to each frame and adds a sticky parity_err output.
module order_rx #(
  parameter int CLKS_PER_BIT = 6,
  parameter int WORD_W       = 32
) (
  input  logic              clock,
  input  logic              CPU_RESETN,
  input  logic              comEn,
  input  logic              data_ping_in,
  output logic [WORD_W-1:0] order_out,
  output logic              order_valid,
  input  logic              order_ack,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy,
  input  logic              err_clr,
`ifdef ORDER_RX_PARITY_EN
  output logic              parity_err,
`endif
  output logic [2:0]        state_dbg
);

  // Handshake: order_valid=1 means order_out holds an unconsumed word; the word is
  // consumed on any rising edge where order_valid=1 and order_ack=1. A new word
  // loaded on that same edge wins, so order_valid stays 1 with fresh data.

`ifdef ORDER_RX_PARITY_EN
  localparam int FRAME_BITS = WORD_W + 1;
`else
  localparam int FRAME_BITS = WORD_W;
`endif
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  localparam logic [CNT_W-1:0] PH_HALF  = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SHIFT   = 3'd1,
    S_STOP    = 3'd2,
    S_WAITLOW = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic com_m, com_s, com_d;
  logic dat_m, dat_s;
  logic [CNT_W-1:0]      phase_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;

  logic ld_start, shift_en, set_ferr, set_ovr, load_word, set_perr, par_ok;

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

`ifdef ORDER_RX_PARITY_EN
  assign par_ok = ~^shift_reg;
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      com_m <= 1'b0;
      com_s <= 1'b0;
      com_d <= 1'b0;
      dat_m <= 1'b0;
      dat_s <= 1'b0;
    end else begin
      com_m <= comEn;
      com_s <= com_m;
      com_d <= com_s;
      dat_m <= data_ping_in;
      dat_s <= dat_m;
    end
  end

  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= S_IDLE;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    shift_en  = 1'b0;
    set_ferr  = 1'b0;
    set_ovr   = 1'b0;
    load_word = 1'b0;
    set_perr  = 1'b0;
    case (state)
      S_IDLE: begin
        if (com_s && !com_d) begin
          ld_start  = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (phase_cnt == PH_HALF) begin
          if (!com_s) begin
            set_ferr  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            shift_en = 1'b1;
            if (bit_cnt == LAST_BIT) state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (!com_s) begin
          state_nxt = S_DONE;
        end else if (phase_cnt == PH_LAST) begin
          set_ferr  = 1'b1;
          state_nxt = S_WAITLOW;
        end
      end
      S_WAITLOW: begin
        if (!com_s) state_nxt = S_IDLE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        if (!par_ok)                         set_perr  = 1'b1;
        else if (!order_valid || order_ack)  load_word = 1'b1;
        else                                 set_ovr   = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // phase_cnt is reused as the stop-window timer once all bits are in.
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      phase_cnt <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (ld_start) begin
      phase_cnt <= CNT_W'(1);
      bit_cnt   <= '0;
    end else if (state == S_SHIFT) begin
      if (shift_en && (bit_cnt == LAST_BIT)) phase_cnt <= '0;
      else if (phase_cnt == PH_LAST)         phase_cnt <= '0;
      else                                   phase_cnt <= phase_cnt + CNT_W'(1);
      if (shift_en) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], dat_s};
        bit_cnt   <= bit_cnt + BIT_W'(1);
      end
    end else if (state == S_STOP) begin
      phase_cnt <= phase_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      order_out   <= '0;
      order_valid <= 1'b0;
    end else if (load_word) begin
      order_out   <= shift_reg[FRAME_BITS-1 -: WORD_W];
      order_valid <= 1'b1;
    end else if (order_valid && order_ack) begin
      order_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (set_ferr)     frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (set_ovr)      overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

`ifdef ORDER_RX_PARITY_EN
  always_ff @(posedge clock or negedge CPU_RESETN) begin
    if (!CPU_RESETN)  parity_err <= 1'b0;
    else if (set_perr) parity_err <= 1'b1;
    else if (err_clr)  parity_err <= 1'b0;
  end
`else
  logic unused_perr;
  assign unused_perr = set_perr;
`endif

endmodule

// File: tb/tb_order_rx.sv
// Randomized frame-level bench for order_rx against a transaction-level reference model.
// Honours ORDER_RX_PARITY_EN the same way as the design.
module tb_order_rx;
  localparam int CPB = 6;
  localparam int W   = 32;
`ifdef ORDER_RX_PARITY_EN
  localparam int FB  = W + 1;
`else
  localparam int FB  = W;
`endif

  logic         clock = 1'b0;
  logic         CPU_RESETN = 1'b0;
  logic         comEn = 1'b0;
  logic         data_ping_in = 1'b0;
  logic [W-1:0] order_out;
  logic         order_valid;
  logic         order_ack = 1'b0;
  logic         frame_err;
  logic         overrun;
  logic         busy;
  logic         err_clr = 1'b0;
  logic         parity_err_w;
  logic [2:0]   state_dbg;

  order_rx #(.CLKS_PER_BIT(CPB), .WORD_W(W)) dut (
    .clock        (clock),
    .CPU_RESETN   (CPU_RESETN),
    .comEn        (comEn),
    .data_ping_in (data_ping_in),
    .order_out    (order_out),
    .order_valid  (order_valid),
    .order_ack    (order_ack),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .busy         (busy),
    .err_clr      (err_clr),
`ifdef ORDER_RX_PARITY_EN
    .parity_err   (parity_err_w),
`endif
    .state_dbg    (state_dbg)
  );

`ifndef ORDER_RX_PARITY_EN
  assign parity_err_w = 1'b0;
`endif

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // reference model state (frame-level)
  logic [W-1:0] exp_out;
  logic         exp_valid, exp_ferr, exp_ovr, exp_perr;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    exp_out = '0; exp_valid = 1'b0; exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
  endtask

  task automatic check_all(input string tag);
    @(negedge clock);
    check({tag, ".out"},   64'(order_out),   64'(exp_out));
    check({tag, ".valid"}, 64'(order_valid), 64'(exp_valid));
    check({tag, ".ferr"},  64'(frame_err),   64'(exp_ferr));
    check({tag, ".ovr"},   64'(overrun),     64'(exp_ovr));
    check({tag, ".busy"},  64'(busy),        64'd0);
`ifdef ORDER_RX_PARITY_EN
    check({tag, ".perr"},  64'(parity_err_w), 64'(exp_perr));
`endif
  endtask

  function automatic logic [FB-1:0] make_frame(input logic [W-1:0] w, input logic par_good);
`ifdef ORDER_RX_PARITY_EN
    return {w, par_good ? ^w : ~^w};
`else
    return w;
`endif
  endfunction

  // driver: comEn high with nbits of the frame, MSB first, CPB clocks each
  task automatic drive_bits(input logic [FB-1:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      comEn = 1'b1;
      data_ping_in = fr[FB-1-i];
      repeat (CPB) tick();
    end
  endtask

  task automatic send_good(input logic [W-1:0] w, input logic ack_at_done, input logic par_good);
    drive_bits(make_frame(w, par_good), FB);
    comEn = 1'b0;
    data_ping_in = 1'b0;
    repeat (3) tick();
    order_ack = ack_at_done;
    tick();
    order_ack = 1'b0;
    if (!par_good) begin
      exp_perr = 1'b1;
      if (ack_at_done) exp_valid = 1'b0;
    end else if (!exp_valid || ack_at_done) begin
      exp_out = w;
      exp_valid = 1'b1;
      exp_q.push_back(w);
    end else begin
      exp_ovr = 1'b1;
    end
  endtask

  task automatic send_short(input logic [W-1:0] w, input int nbits);
    drive_bits(make_frame(w, 1'b1), nbits);
    comEn = 1'b0;
    data_ping_in = 1'b0;
    repeat (CPB + 3) tick();
    exp_ferr = 1'b1;
  endtask

  task automatic send_long(input logic [W-1:0] w);
    drive_bits(make_frame(w, 1'b1), FB);
    data_ping_in = 1'b0;
    repeat (10 * CPB) tick();
    comEn = 1'b0;
    repeat (4) tick();
    exp_ferr = 1'b1;
  endtask

  task automatic pulse_ack();
    order_ack = 1'b1;
    tick();
    order_ack = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_ferr = 1'b0; exp_ovr = 1'b0; exp_perr = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    check_all("reset");
    CPU_RESETN = 1'b1;
    repeat (3) tick();

    // nominal frame, valid holds without ack, then consumed
    send_good(32'hA5C3_0F01, 1'b0, 1'b1);
    check_all("nominal");
    repeat (20) tick();
    check_all("nominal_hold");
    pulse_ack();
    check_all("nominal_ack");

    // overrun
    repeat (4) tick();
    send_good(32'h0000_0001, 1'b0, 1'b1);
    repeat (4) tick();
    send_good(32'hFFFF_FFFF, 1'b0, 1'b1);
    check_all("overrun");
    pulse_clr();
    check_all("overrun_clr");

    // ack and load in the DONE cycle
    repeat (4) tick();
    send_good(32'h1234_5678, 1'b1, 1'b1);
    check_all("collision");

    // short frame, then recovery
    repeat (4) tick();
    send_short(32'hCAFE_F00D, 20);
    check_all("short");
    pulse_ack();
    pulse_clr();
    repeat (3) tick();
    send_good(32'hDEAD_BEEF, 1'b0, 1'b1);
    check_all("after_short");

    // long frame, then recovery
    pulse_ack();
    repeat (3) tick();
    send_long(32'h5555_AAAA);
    check_all("long");
    repeat (3) tick();
    send_good(32'h0000_FFFF, 1'b0, 1'b1);
    check_all("after_long");

    // reset mid-frame
    pulse_ack();
    repeat (3) tick();
    drive_bits(make_frame(32'h1357_9BDF, 1'b1), 15);
    CPU_RESETN = 1'b0;
    #1;
    model_reset();
    check("rst_mid.out",   64'(order_out),   64'd0);
    check("rst_mid.valid", 64'(order_valid), 64'd0);
    check("rst_mid.ferr",  64'(frame_err),   64'd0);
    check("rst_mid.ovr",   64'(overrun),     64'd0);
    check("rst_mid.busy",  64'(busy),        64'd0);
    check("rst_mid.perr",  64'(parity_err_w), 64'd0);
    comEn = 1'b0;
    data_ping_in = 1'b0;
    repeat (2) tick();
    CPU_RESETN = 1'b1;
    repeat (3) tick();
`ifdef ORDER_RX_PARITY_EN
    send_good(32'h8000_0000, 1'b0, 1'b0);
`else
    send_good(32'h8000_0000, 1'b0, 1'b1);
`endif
    check_all("after_reset");

    // randomized frames
    pulse_clr();
    for (int n = 0; n < 25; n++) begin
      int kind;
      logic [W-1:0] w;
      w = $urandom();
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(3, 10)) tick();
      if ($urandom_range(0, 2) == 0) pulse_ack();
      if ($urandom_range(0, 3) == 0) pulse_clr();
      if (kind < 6)      send_good(w, 1'($urandom_range(0, 1)), 1'b1);
      else if (kind < 8) send_short(w, $urandom_range(1, FB - 1));
      else               send_long(w);
      check_all($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
